regfile_wb: RTL

- Write-back end of the execute path: accepts the ALU result word, its write-enable and the destination register number.
- Holds them for one cycle in a WB stage register, then commits them into a 32x32 general register file.
- Provides two read ports to decode, with write-through bypass of the pending result, plus trace/debug outputs and a retired-instruction counter.

---
 rtl/regfile_wb_pkg.sv | 7 +
 rtl/regfile_wb_array.sv | 35 +++
 rtl/regfile_wb.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths and constants for the write-back stage and its register array.
package regfile_wb_pkg;
  localparam int          REG_AW   = 5;
  localparam int          DATA_W   = 32;
  localparam int          STRB_W   = 4;
  localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_wb_array.sv
// General register array: async clear, one write port, two combinational
// read ports; register 0 is hardwired to zero on read.
module regfile_array
  import regfile_wb_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wen && (waddr != REG_ZERO)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == REG_ZERO) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO) ? '0 : mem[raddr2];

endmodule

// File: rtl/regfile_wb.sv
// Write-back stage: one-cycle stage register in front of the register file,
// with bypass of the pending result, trace outputs and a retire counter.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic [31:0]       wb_pc,
  input  logic              wb_stall,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2,
  output logic [31:0]       debug_wb_pc,
  output logic [STRB_W-1:0] debug_wb_rf_wen,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DW-1:0]     debug_wb_rf_wdata,
  output logic [31:0]       retire_cnt
);

  logic              v_q;
  logic              en_q;
  logic [REG_AW-1:0] addr_q;
  logic [DW-1:0]     data_q;
  logic [31:0]       pc_q;
  logic              pend;
  logic              commit;
  logic [DW-1:0]     arr_rdata1;
  logic [DW-1:0]     arr_rdata2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q    <= 1'b0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pc_q   <= '0;
    end else if (!wb_stall) begin
      v_q    <= wb_valid;
      en_q   <= wb_en;
      addr_q <= wb_addr;
      data_q <= wb_data;
      pc_q   <= wb_pc;
    end
  end

  assign pend   = v_q & en_q & (addr_q != REG_ZERO);
  assign commit = pend & ~wb_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt <= '0;
    end else if (v_q && !wb_stall) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  regfile_array #(
    .NREG (NREG),
    .DW   (DW)
  ) u_array (
    .clk    (clk),
    .resetn (resetn),
    .wen    (commit),
    .waddr  (addr_q),
    .wdata  (data_q),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  // Bypass uses pend, not commit: a stalled result is still the newest value.
  assign rdata1 = (raddr1 == REG_ZERO)             ? '0     :
                  (pend && (raddr1 == addr_q))     ? data_q : arr_rdata1;
  assign rdata2 = (raddr2 == REG_ZERO)             ? '0     :
                  (pend && (raddr2 == addr_q))     ? data_q : arr_rdata2;

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {STRB_W{commit}};
  assign debug_wb_rf_wnum  = addr_q;
  assign debug_wb_rf_wdata = data_q;

endmodule
